// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  // Default widths for the byte-addressed PC and the instruction word.
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 32;

  // Byte distance between consecutive instructions.
  localparam int PC_INC = 4;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: +4 advance with natural wrap, branch redirect mux
// and, when FETCH_ALIGN_CHECK_EN is defined, a sticky misaligned-target flag
// with the target forced to a word boundary.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] target_eff;
  logic [ADDR_W-1:0] pc_next;

`ifdef FETCH_ALIGN_CHECK_EN
  // Redirect lands on the containing word; low bits are dropped.
  assign target_eff = {branch_target[ADDR_W-1:2], 2'b00};

  // Sticky flag raised by any redirect to a non-word-aligned target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_err <= 1'b0;
    else if (branch_valid && (branch_target[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`else
  assign target_eff   = branch_target;
  assign misalign_err = 1'b0;
`endif

  // Next PC: redirect wins over sequential advance; otherwise hold.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc;
    if (branch_valid)
      pc_next = target_eff;
    else if (advance)
      pc_next = pc + INC;  // wraps modulo 2^ADDR_W by width truncation
  end

  // PC state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the instruction memory
// address, captures the returned word into an output register and hands it
// to decode over a valid/ready handshake with stall, start/stop and branch
// flush. Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned-branch check).
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  output logic [15:0]        fetch_count,
  output logic               misalign_err
);

  fetch_state_e      state, state_next;
  logic              load;
  logic              accept;
  logic [ADDR_W-1:0] pc;

  assign accept    = if_valid && id_ready;
  assign imem_addr = pc;  // straight from the register, no input path

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .advance       (load),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .pc            (pc),
    .misalign_err  (misalign_err)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state and load decision; a redirect overrides both.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en)
          state_next = FETCH;
      end
      FETCH: begin
        load = fetch_en && (!if_valid || id_ready);
        if (if_valid && !id_ready)
          state_next = HOLD;
        else if (!fetch_en)
          state_next = IDLE;
      end
      HOLD: begin
        load = fetch_en && id_ready;
        if (id_ready)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    if (branch_valid) begin
      load       = 1'b0;
      state_next = fetch_en ? FETCH : IDLE;
    end
  end

  // Fetch output register: flush on redirect, fill on load, drain on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (branch_valid) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_instr;
      if_pc    <= pc;
    end else if (accept) begin
      if_valid <= 1'b0;
    end
  end

  // Handshake counter; a handshake coinciding with a redirect still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_count <= '0;
    else if (accept)
      fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus pushes the expected
// {pc, instr} of each instruction decode should accept, a negedge monitor
// pops and compares on every handshake.
module tb_fetch_controller;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               fetch_en;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready;
  logic [15:0]        fetch_count;
  logic               misalign_err;

  int   checks  = 0;
  int   errors  = 0;
  int   hs_seen = 0;
  exp_t sb[$];

  fetch_controller #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  // Memory model: byte at address a holds a.
  function automatic logic [INSTR_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {a, a1, a2, a3};
  endfunction

  assign imem_instr = word_at(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word_at(pc);
    sb.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready) begin
      hs_seen++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hs_pc", 32'(if_pc), 32'(e.pc));
        check("hs_instr", if_instr, e.instr);
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] exp_pc;
    logic              exp_mis;

    reset         = 1'b1;
    fetch_en      = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    id_ready      = 1'b0;
    #2;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", 32'(if_pc), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Start-up: FETCH after first edge, first load on the second.
    tick();
    push(8'h00);
    push(8'h04);
    fetch_en = 1'b1;
    id_ready = 1'b1;
    tick();
    check("start_valid_n", 32'(if_valid), 32'd0);
    tick();
    check("start_valid_n1", 32'(if_valid), 32'd1);
    check("first_pc", 32'(if_pc), 32'd0);
    check("first_instr", if_instr, 32'h00010203);
    tick();
    check("second_instr", if_instr, 32'h04050607);
    check("count_1", 32'(fetch_count), 32'd1);
    tick();
    check("count_2", 32'(fetch_count), 32'd2);

    // Stall with if_pc = 8.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(if_pc), 32'd8);
      check("stall_instr", if_instr, 32'h08090A0B);
      check("stall_addr", 32'(imem_addr), 32'd12);
      check("stall_count", 32'(fetch_count), 32'd2);
    end
    push(8'h08);
    push(8'h0C);
    id_ready = 1'b1;
    tick();
    check("resume_pc", 32'(if_pc), 32'd12);
    check("resume_count", 32'(fetch_count), 32'd3);

    // Branch to 0x40 while holding pc 12; the handshake of 12 still counts.
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    check("br_bubble", 32'(if_valid), 32'd0);
    check("br_addr", 32'(imem_addr), 32'h40);
    check("br_count", 32'(fetch_count), 32'd4);
    push(8'h40);
    tick();
    check("br_valid", 32'(if_valid), 32'd1);
    check("br_pc", 32'(if_pc), 32'h40);
    check("br_instr", if_instr, 32'h40414243);

    // Run through the 252 -> 0 wrap.
    for (int p = 'h44; p <= 'h104; p += 4) begin
      logic [ADDR_W-1:0] pb;
      pb = 8'(p);
      push(pb);
      tick();
      check("run_valid", 32'(if_valid), 32'd1);
      check("run_pc", 32'(if_pc), 32'(pb));
    end
    check("run_count", 32'(fetch_count), 32'(hs_seen));

    // Misaligned redirect.
`ifdef FETCH_ALIGN_CHECK_EN
    exp_pc  = 8'h40;
    exp_mis = 1'b1;
`else
    exp_pc  = 8'h42;
    exp_mis = 1'b0;
`endif
    branch_valid  = 1'b1;
    branch_target = 8'h42;
    tick();
    branch_valid = 1'b0;
    check("mis_bubble", 32'(if_valid), 32'd0);
    push(exp_pc);
    tick();
    check("mis_pc", 32'(if_pc), 32'(exp_pc));
    check("mis_flag", 32'(misalign_err), 32'(exp_mis));
    push(exp_pc + 8'd4);
    tick();
    check("mis_sticky", 32'(misalign_err), 32'(exp_mis));

    // Asynchronous reset mid-stream with an instruction in flight.
    check("pre_rst_valid", 32'(if_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_pc", 32'(if_pc), 32'd0);
    check("async_instr", if_instr, 32'd0);
    check("async_count", 32'(fetch_count), 32'd0);
    check("async_addr", 32'(imem_addr), 32'd0);
    check("async_mis", 32'(misalign_err), 32'd0);
    sb.delete();
    fetch_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("idle_valid", 32'(if_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
